// File: rtl/hyperbus_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : hyperbus_wb_bridge
//  Description : Wishbone B4 classic slave in front of the HyperBus
//                controller request port. Each 32-bit access becomes a
//                pair of 16-bit controller words (little-endian, low word
//                first). Read beats are collected and write beats supplied
//                under rrq/wrq sequencing. The result returns to the master
//                as a one-cycle ack or err.
//                Optional watchdog: define HBUS_BRIDGE_TIMEOUT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module hyperbus_wb_bridge #(
    parameter int WIDTH          = 8,
    parameter int ADR_WIDTH      = 24,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    // Wishbone slave
    input  logic [ADR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    // HyperBus controller request port
    output logic [31:0]          hb_adr_o,
    output logic [2*WIDTH-1:0]   hb_dat_o,
    input  logic [2*WIDTH-1:0]   hb_dat_i,
    input  logic                 hb_dready_i,
    input  logic                 hb_dvalid_i,
    input  logic                 hb_busy_i,
    input  logic                 hb_error_i,
    output logic                 hb_wrq_o,
    output logic                 hb_rrq_o
);

    // Controller word width; the bridge always moves a pair of words.
    localparam int c_WORD_W = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_BEAT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_DRAIN = 3'd4,
        S_RESP  = 3'd5,
        S_FAULT = 3'd6
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic        r_abort;
    logic [31:0] r_wdat;
    logic [31:0] r_rdata;

    logic        w_access;
    logic        w_bad;
    logic        w_active;
    logic        w_live;
    logic [31:0] w_hb_adr;

    assign w_access = wb_cyc_i & wb_stb_i;
    // Illegal selects/alignment and a sticky controller error all reject up front.
    assign w_bad    = hb_error_i | (wb_sel_i != 4'hF) | (wb_adr_i[1:0] != 2'b00);
    assign w_active = (r_state == S_REQ) | (r_state == S_BEAT0) |
                      (r_state == S_BEAT1) | (r_state == S_DRAIN);
    // A response is only returned if the master is still in the cycle.
    assign w_live   = wb_cyc_i & ~r_abort;
    // Byte address to controller word address: drop the 32-bit offset, x2.
    assign w_hb_adr = {{(33 - ADR_WIDTH){1'b0}}, wb_adr_i[ADR_WIDTH-1:2], 1'b0};

`ifdef HBUS_BRIDGE_TIMEOUT_EN
    localparam int c_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_WDOG_W-1:0] r_wdog;
    logic                w_timeout;

    assign w_timeout = w_active & (r_wdog == c_WDOG_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: restarts whenever idle, counts every cycle a transfer is open.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE) begin
            r_wdog <= '0;
        end else if (w_active) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end
`else
    logic w_timeout;
    logic w_unused_tmo;

    assign w_timeout    = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

    // Transfer sequencer: all bus outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_abort  <= 1'b0;
            r_wdat   <= '0;
            r_rdata  <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            hb_adr_o <= '0;
            hb_dat_o <= '0;
            hb_wrq_o <= 1'b0;
            hb_rrq_o <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;

            // Master walked away: finish on HyperBus but stay silent.
            if (w_active && !wb_cyc_i) begin
                r_abort <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (w_access) begin
                        if (w_bad) begin
                            wb_err_o <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_we     <= wb_we_i;
                            r_wdat   <= wb_dat_i;
                            r_rdata  <= '0;
                            hb_adr_o <= w_hb_adr;
                            hb_dat_o <= wb_dat_i[c_WORD_W-1:0];
                            hb_wrq_o <= wb_we_i;
                            hb_rrq_o <= ~wb_we_i;
                            r_state  <= S_REQ;
                        end
                    end
                end

                S_REQ: begin
                    if (hb_error_i) begin
                        hb_wrq_o <= 1'b0;
                        hb_rrq_o <= 1'b0;
                        wb_err_o <= w_live;
                        r_state  <= S_FAULT;
                    end else if (hb_busy_i) begin
                        r_state <= S_BEAT0;
                    end
                end

                S_BEAT0: begin
                    if (hb_error_i) begin
                        hb_wrq_o <= 1'b0;
                        hb_rrq_o <= 1'b0;
                        wb_err_o <= w_live;
                        r_state  <= S_FAULT;
                    end else if (r_we && hb_dready_i) begin
                        hb_dat_o <= r_wdat[2*c_WORD_W-1:c_WORD_W];
                        r_state  <= S_BEAT1;
                    end else if (!r_we && hb_dvalid_i) begin
                        r_rdata[c_WORD_W-1:0] <= hb_dat_i;
                        r_state <= S_BEAT1;
                    end
                end

                S_BEAT1: begin
                    if (hb_error_i) begin
                        hb_wrq_o <= 1'b0;
                        hb_rrq_o <= 1'b0;
                        wb_err_o <= w_live;
                        r_state  <= S_FAULT;
                    end else if ((r_we && hb_dready_i) || (!r_we && hb_dvalid_i)) begin
                        if (!r_we) begin
                            r_rdata[2*c_WORD_W-1:c_WORD_W] <= hb_dat_i;
                        end
                        hb_wrq_o <= 1'b0;
                        hb_rrq_o <= 1'b0;
                        r_state  <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (hb_error_i) begin
                        wb_err_o <= w_live;
                        r_state  <= S_FAULT;
                    end else if (!hb_busy_i) begin
                        wb_ack_o <= w_live;
                        wb_dat_o <= (r_we || !w_live) ? 32'h0 : r_rdata;
                        r_state  <= S_RESP;
                    end
                end

                // ack/err pulse is visible during RESP and FAULT.
                S_RESP:  r_state <= S_IDLE;
                S_FAULT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Watchdog expiry overrides whatever the open transfer was doing.
            if (w_timeout) begin
                hb_wrq_o <= 1'b0;
                hb_rrq_o <= 1'b0;
                wb_ack_o <= 1'b0;
                wb_dat_o <= '0;
                wb_err_o <= w_live;
                r_state  <= S_RESP;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_wb_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hyperbus_wb_bridge
//  Description : Directed bench for hyperbus_wb_bridge; the controller side
//                is driven cycle by cycle from the stimulus sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hyperbus_wb_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [31:0] hb_adr_o;
    logic [15:0] hb_dat_o, hb_dat_i;
    logic        hb_dready_i, hb_dvalid_i, hb_busy_i, hb_error_i;
    logic        hb_wrq_o, hb_rrq_o;

    int n_vec = 0;
    int n_bad = 0;

    hyperbus_wb_bridge #(
        .WIDTH(8), .ADR_WIDTH(24), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .hb_adr_o(hb_adr_o), .hb_dat_o(hb_dat_o), .hb_dat_i(hb_dat_i),
        .hb_dready_i(hb_dready_i), .hb_dvalid_i(hb_dvalid_i),
        .hb_busy_i(hb_busy_i), .hb_error_i(hb_error_i),
        .hb_wrq_o(hb_wrq_o), .hb_rrq_o(hb_rrq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_start(input logic we, input logic [23:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel);
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
    endtask

    task automatic wb_stop();
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        hb_dat_i = '0; hb_dready_i = 1'b0; hb_dvalid_i = 1'b0;
        hb_busy_i = 1'b0; hb_error_i = 1'b0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("rst_err", {31'd0, wb_err_o}, 32'd0);
        chk("rst_req", {30'd0, hb_rrq_o, hb_wrq_o}, 32'd0);
        chk("rst_adr", hb_adr_o, 32'd0);
        chk("rst_dat", {16'd0, hb_dat_o}, 32'd0);
        rst = 1'b0;
        tick();

        // Read 0x100 -> controller word address 0x80, data 0x56781234
        wb_start(1'b0, 24'h000100, 32'h0, 4'hF);
        tick();
        chk("rd_rrq", {31'd0, hb_rrq_o}, 32'd1);
        chk("rd_wrq", {31'd0, hb_wrq_o}, 32'd0);
        chk("rd_adr", hb_adr_o, 32'h80);
        hb_busy_i = 1'b1;
        tick();
        chk("rd_rrq_beat0", {31'd0, hb_rrq_o}, 32'd1);
        hb_dvalid_i = 1'b1; hb_dat_i = 16'h1234;
        tick();
        hb_dat_i = 16'h5678;
        tick();
        chk("rd_rrq_drain", {31'd0, hb_rrq_o}, 32'd0);
        hb_dvalid_i = 1'b0; hb_busy_i = 1'b0;
        tick();
        chk("rd_ack", {31'd0, wb_ack_o}, 32'd1);
        chk("rd_err", {31'd0, wb_err_o}, 32'd0);
        chk("rd_data", wb_dat_o, 32'h56781234);
        wb_stop();
        tick();
        chk("rd_ack_pulse", {31'd0, wb_ack_o}, 32'd0);

        // Write 0x8 data 0xCAFEBEEF
        wb_start(1'b1, 24'h000008, 32'hCAFEBEEF, 4'hF);
        tick();
        chk("wr_wrq", {31'd0, hb_wrq_o}, 32'd1);
        chk("wr_rrq", {31'd0, hb_rrq_o}, 32'd0);
        chk("wr_adr", hb_adr_o, 32'h4);
        chk("wr_dat0", {16'd0, hb_dat_o}, 32'hBEEF);
        hb_busy_i = 1'b1;
        tick();
        chk("wr_dat0_hold", {16'd0, hb_dat_o}, 32'hBEEF);
        hb_dready_i = 1'b1;
        tick();
        chk("wr_dat1", {16'd0, hb_dat_o}, 32'hCAFE);
        chk("wr_wrq_beat1", {31'd0, hb_wrq_o}, 32'd1);
        tick();
        chk("wr_wrq_drain", {31'd0, hb_wrq_o}, 32'd0);
        hb_dready_i = 1'b0;
        tick();
        chk("wr_no_early_ack", {31'd0, wb_ack_o}, 32'd0);
        hb_busy_i = 1'b0;
        tick();
        chk("wr_ack", {31'd0, wb_ack_o}, 32'd1);
        chk("wr_datout", wb_dat_o, 32'h0);
        wb_stop();
        tick();

        // Illegal byte selects
        wb_start(1'b0, 24'h000010, 32'h0, 4'b0011);
        tick();
        chk("sel_err", {31'd0, wb_err_o}, 32'd1);
        chk("sel_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("sel_req", {30'd0, hb_rrq_o, hb_wrq_o}, 32'd0);
        wb_stop();
        tick();
        chk("sel_err_pulse", {31'd0, wb_err_o}, 32'd0);

        // Misaligned address
        wb_start(1'b1, 24'h000002, 32'h11112222, 4'hF);
        tick();
        chk("mis_err", {31'd0, wb_err_o}, 32'd1);
        chk("mis_req", {30'd0, hb_rrq_o, hb_wrq_o}, 32'd0);
        wb_stop();
        tick();

        // Controller error during BEAT0 of a read
        wb_start(1'b0, 24'h000010, 32'h0, 4'hF);
        tick();
        hb_busy_i = 1'b1;
        tick();
        hb_error_i = 1'b1;
        tick();
        chk("herr_rrq", {31'd0, hb_rrq_o}, 32'd0);
        chk("herr_err", {31'd0, wb_err_o}, 32'd1);
        chk("herr_ack", {31'd0, wb_ack_o}, 32'd0);
        wb_stop();
        hb_busy_i = 1'b0;
        tick();
        chk("herr_err_pulse", {31'd0, wb_err_o}, 32'd0);
        // Sticky error rejects the next access without a request
        wb_start(1'b0, 24'h000020, 32'h0, 4'hF);
        tick();
        chk("sticky_err", {31'd0, wb_err_o}, 32'd1);
        chk("sticky_req", {30'd0, hb_rrq_o, hb_wrq_o}, 32'd0);
        wb_stop();
        hb_error_i = 1'b0;
        tick();

        // Back-to-back read then write
        wb_start(1'b0, 24'h000020, 32'h0, 4'hF);
        tick();
        hb_busy_i = 1'b1;
        tick();
        hb_dvalid_i = 1'b1; hb_dat_i = 16'hAAAA;
        tick();
        hb_dat_i = 16'h5555;
        tick();
        hb_dvalid_i = 1'b0; hb_busy_i = 1'b0;
        tick();
        chk("b2b_rd_ack", {31'd0, wb_ack_o}, 32'd1);
        chk("b2b_rd_data", wb_dat_o, 32'h5555AAAA);
        wb_start(1'b1, 24'h000024, 32'h12345678, 4'hF);
        tick();
        chk("b2b_idle_req", {30'd0, hb_rrq_o, hb_wrq_o}, 32'd0);
        tick();
        chk("b2b_wr_req", {30'd0, hb_rrq_o, hb_wrq_o}, 32'd1);
        chk("b2b_wr_adr", hb_adr_o, 32'h12);
        chk("b2b_wr_dat0", {16'd0, hb_dat_o}, 32'h5678);
        hb_busy_i = 1'b1;
        tick();
        hb_dready_i = 1'b1;
        tick();
        chk("b2b_wr_dat1", {16'd0, hb_dat_o}, 32'h1234);
        tick();
        hb_dready_i = 1'b0; hb_busy_i = 1'b0;
        tick();
        chk("b2b_wr_ack", {31'd0, wb_ack_o}, 32'd1);
        wb_stop();
        tick();

        // Master drops cyc mid-transaction: bus completes, no ack
        wb_start(1'b0, 24'h000040, 32'h0, 4'hF);
        tick();
        wb_stop();
        hb_busy_i = 1'b1;
        tick();
        chk("abort_rrq_held", {31'd0, hb_rrq_o}, 32'd1);
        hb_dvalid_i = 1'b1; hb_dat_i = 16'h0F0F;
        tick();
        tick();
        hb_dvalid_i = 1'b0; hb_busy_i = 1'b0;
        tick();
        chk("abort_no_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        tick();

        // Controller never starts
        wb_start(1'b0, 24'h000080, 32'h0, 4'hF);
        tick();
`ifdef HBUS_BRIDGE_TIMEOUT_EN
        repeat (15) tick();
        chk("tmo_not_yet", {31'd0, wb_err_o}, 32'd0);
        tick();
        chk("tmo_err", {31'd0, wb_err_o}, 32'd1);
        chk("tmo_rrq", {31'd0, hb_rrq_o}, 32'd0);
        wb_stop();
        tick();
`else
        repeat (40) tick();
        chk("hang_no_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
        chk("hang_rrq_held", {31'd0, hb_rrq_o}, 32'd1);
        hb_busy_i = 1'b1;
        tick();
        hb_dvalid_i = 1'b1; hb_dat_i = 16'hBEEF;
        tick();
        hb_dat_i = 16'hDEAD;
        tick();
        hb_dvalid_i = 1'b0; hb_busy_i = 1'b0;
        tick();
        chk("hang_late_ack", {31'd0, wb_ack_o}, 32'd1);
        chk("hang_late_data", wb_dat_o, 32'hDEADBEEF);
        wb_stop();
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
